mic_clk_gen: RTL and testbench
==============================

MIC_CLK_GEN -- requirements
Module: mic_clk_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of generated microphone clock channels.
REQ-002 SHALL have parameter DIV_W, default 8: width of each per-channel divide value.
REQ-003 SHALL have parameter LOCK_DLY, default 16: number of refclk cycles lock must be stable before output.
REQ-004 SHALL have port refclk, input, 1: sole clock, the PLL output; rising edge active.
REQ-005 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-006 SHALL have port pll_locked, input, 1: raw PLL lock, asynchronous to refclk.
REQ-007 SHALL have port ch_en, input, NUM_CH: per-channel enable.
REQ-008 SHALL have port div_val, input, NUM_CH*DIV_W: per-channel half-period minus one; channel i uses bits [i*DIV_W +: DIV_W].
REQ-009 SHALL have port sync_in, input, 1: single-cycle phase-align request.
REQ-010 SHALL have port outclk, output, NUM_CH: generated clocks.
REQ-011 SHALL have port tick, output, NUM_CH: one-cycle strobe coincident with each outclk rising edge.
REQ-012 SHALL have port locked, output, 1: qualified lock.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchroniser (lock_s) before any use.
REQ-014 SHALL implement the FSM IDLE -> SETTLE on lock_s=1; SETTLE -> RUN after LOCK_DLY consecutive cycles of lock_s=1; SETTLE or RUN -> IDLE on lock_s=0, clearing the settle counter.
REQ-015 SHALL register locked high exactly when the FSM is in RUN; locked rises LOCK_DLY+3 refclk edges after pll_locked rises.
REQ-016 Per channel, SHALL toggle outclk when the counter equals the latched divide (div_lat) and clear the counter; otherwise the counter increments; period = 2*(div_lat+1) cycles; div_val=0 gives refclk/2.
REQ-017 SHALL sample div_val into div_lat only at the start of a new period: channel start, the falling-to-rising toggle, or sync; a mid-period change never alters the current period.
REQ-018 An idle channel with ch_en=1 in RUN SHALL drive outclk=1 and tick=1 on the next edge, with counter=0 and div_lat loaded.
REQ-019 When ch_en falls, the channel SHALL complete the current period and then hold outclk=0, tick=0, with no runt pulse.
REQ-020 Leaving RUN SHALL force all outclk and tick to 0 on the next edge; the channels restart per REQ-018 on re-entry to RUN.
REQ-021 tick SHALL never assert outside RUN or for a disabled channel.

Reset
REQ-022 rst=1 SHALL asynchronously clear: FSM=IDLE, synchroniser, counters, div_lat, outclk=0, tick=0, locked=0.
REQ-023 Reset deassertion SHALL be synchronised externally; no output changes until lock_s=1.

Configuration
REQ-024 With MIC_CLK_GEN_PHASE_ALIGN_EN defined, sync_in=1 in RUN SHALL, on the next edge, set every enabled channel to counter=0, outclk=1, tick=1 and div_lat=div_val; sync_in wins over a coincident toggle.
REQ-025 Without MIC_CLK_GEN_PHASE_ALIGN_EN, sync_in SHALL be present but ignored, and no alignment logic is synthesised.
REQ-026 sync_in outside RUN SHALL be ignored in both configurations.

Structure
REQ-027 Package mic_clk_pkg SHALL hold the FSM state enum (IDLE, SETTLE, RUN) and the default constants for NUM_CH, DIV_W and LOCK_DLY.
REQ-028 SHALL use one sub-module, mic_clk_div_ch, instantiated NUM_CH times; it holds the counter, div_lat, outclk and tick and takes run, en, div and sync inputs.

Verification
REQ-029 rst=1 with arbitrary inputs -> outclk=0, tick=0, locked=0 throughout.
REQ-030 pll_locked rises at edge 0 with LOCK_DLY=16 -> locked=1 at edge 19 and not before; ch0 en, div 7 -> outclk period 16 cycles, 8 high, tick every 16.
REQ-031 ch0 div 7 changed to 3 mid-high phase -> current period stays 16 cycles, the following periods are 8 cycles.
REQ-032 ch_en[0] dropped 3 cycles into high phase -> remaining high 5 cycles plus low 8 cycles, then held at 0; no tick afterwards.
REQ-033 pll_locked drops in RUN -> locked=0 and all outclk=0 within 4 edges; on relock, channels restart with tick after LOCK_DLY+3 edges.
REQ-034 With the macro, ch0 div 7 and ch1 div 3 at different phases, sync_in pulse -> both rise with tick on the next edge and stay aligned thereafter; without the macro -> no phase change.

Source files
------------

// File: rtl/mic_clk_pkg.sv
// mic_clk_pkg: lock FSM encoding and default sizing shared by the mic clock generator.
package mic_clk_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
   localparam int NUM_CH_DEF = 4;
   localparam int DIV_W_DEF = 8;
   localparam int LOCK_DLY_DEF = 16;
endpackage

// File: rtl/mic_clk_div_ch.sv
// mic_clk_div_ch: one divided microphone clock; sync alignment only with MIC_CLK_GEN_PHASE_ALIGN_EN.
module mic_clk_div_ch #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic             sync,
   output logic             outclk,
   output logic             tick
);
   logic [DIV_W-1:0] cnt, div_lat;
   logic active, do_sync, wrap;
`ifdef MIC_CLK_GEN_PHASE_ALIGN_EN
   assign do_sync = sync & en;
`else
   logic unused_sync;
   assign unused_sync = sync;
   assign do_sync = 1'b0;
`endif
   assign wrap = cnt == div_lat;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         active <= 1'b0;
         outclk <= 1'b0;
         tick <= 1'b0;
         cnt <= '0;
         div_lat <= '0;
      end else if (!run) begin
         active <= 1'b0;
         outclk <= 1'b0;
         tick <= 1'b0;
         cnt <= '0;
      end else if (do_sync || (en && (!active || (wrap && !outclk)))) begin
         // every new period starts high, so div is only sampled here
         active <= 1'b1;
         outclk <= 1'b1;
         tick <= 1'b1;
         cnt <= '0;
         div_lat <= div;
      end else begin
         tick <= 1'b0;
         if (active && wrap) begin
            cnt <= '0;
            outclk <= 1'b0;
            active <= outclk;
         end else if (active) cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/mic_clk_gen.sv
// mic_clk_gen: lock-qualified multi-channel mic clock divider.
// Optional phase alignment on sync_in: define MIC_CLK_GEN_PHASE_ALIGN_EN.
module mic_clk_gen
   import mic_clk_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DIV_W = DIV_W_DEF,
   parameter int LOCK_DLY = LOCK_DLY_DEF
) (
   input  logic                    refclk,
   input  logic                    rst,
   input  logic                    pll_locked,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic [NUM_CH*DIV_W-1:0] div_val,
   input  logic                    sync_in,
   output logic [NUM_CH-1:0]       outclk,
   output logic [NUM_CH-1:0]       tick,
   output logic                    locked
);
   localparam int CW = $clog2(LOCK_DLY + 1);
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic lock_m, lock_s, run;
   always_ff @(posedge refclk or posedge rst)
      if (rst) {lock_s, lock_m} <= 2'b00;
      else {lock_s, lock_m} <= {lock_m, pll_locked};
   always_ff @(posedge refclk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         locked <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         locked <= state == RUN;
      end
   always_comb begin
      state_nxt = state;
      cnt_nxt = '0;
      if (!lock_s) state_nxt = IDLE;
      else if (state == IDLE) state_nxt = SETTLE;
      else if (state == SETTLE) begin
         state_nxt = cnt == CW'(LOCK_DLY - 1) ? RUN : SETTLE;
         cnt_nxt = cnt + 1'b1;
      end
   end
   assign run = state == RUN;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mic_clk_div_ch #(.DIV_W(DIV_W)) u_ch (
         .clk(refclk),
         .rst(rst),
         .run(run),
         .en(ch_en[i]),
         .div(div_val[i*DIV_W +: DIV_W]),
         .sync(sync_in),
         .outclk(outclk[i]),
         .tick(tick[i])
      );
   end
endmodule

// File: tb/tb_mic_clk_gen.sv
// tb_mic_clk_gen: directed table and sequence checks for mic_clk_gen at default parameters.
module tb_mic_clk_gen;
   logic refclk = 1'b0;
   logic rst, pll_locked, sync_in, locked;
   logic [3:0] ch_en, outclk, tick, exp_o, exp_t;
   logic [31:0] div_val;
   int checks = 0, failures = 0, bad_tick = 0;
   int h, l, found;
   typedef struct {
      logic [7:0] div;
      int exp_high;
      int exp_low;
   } vec_t;
   vec_t vecs[5];

   mic_clk_gen dut (
      .refclk(refclk),
      .rst(rst),
      .pll_locked(pll_locked),
      .ch_en(ch_en),
      .div_val(div_val),
      .sync_in(sync_in),
      .outclk(outclk),
      .tick(tick),
      .locked(locked)
   );

   always #5 refclk = ~refclk;

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic count_level(input logic lvl, output int n);
      n = 0;
      while (outclk[0] == lvl && n < 100) begin
         if (n > 0 && tick[0]) bad_tick++;
         n++;
         step();
      end
   endtask

   task automatic restart(input logic [7:0] d);
      ch_en[0] = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (tick[0]) bad_tick++;
      end
      check("idle_low", {31'd0, outclk[0]}, 32'd0);
      div_val[7:0] = d;
      ch_en[0] = 1'b1;
      step();
      check("start_rise", {30'd0, outclk[0], tick[0]}, 32'd3);
   endtask

   initial begin
      vecs[0] = '{8'd0, 1, 1};
      vecs[1] = '{8'd1, 2, 2};
      vecs[2] = '{8'd3, 4, 4};
      vecs[3] = '{8'd7, 8, 8};
      vecs[4] = '{8'd15, 16, 16};
      // reset holds everything low regardless of inputs
      rst = 1'b1;
      pll_locked = 1'b1;
      ch_en = 4'hF;
      sync_in = 1'b0;
      div_val = $urandom;
      for (int i = 0; i < 6; i++) begin
         sync_in = i[0];
         div_val = $urandom;
         step();
         check("reset", {23'd0, outclk, tick, locked}, 32'd0);
      end
      pll_locked = 1'b0;
      sync_in = 1'b0;
      ch_en = 4'b0001;
      div_val = '0;
      div_val[7:0] = 8'd7;
      #2 rst = 1'b0;
      repeat (3) step();
      // lock qualification: pll_locked seen at edge 0, locked at edge 19
      pll_locked = 1'b1;
      for (int e = 0; e < 19; e++) begin
         sync_in = e < 16;
         step();
         check("lock_wait", {23'd0, locked, outclk, tick}, 32'd0);
      end
      sync_in = 1'b0;
      step();
      check("lock_rise", {23'd0, locked, outclk, tick}, {23'd0, 1'b1, 4'b0001, 4'b0001});
      count_level(1'b1, h);
      check("lock_high", h, 8);
      count_level(1'b0, l);
      check("lock_low", l, 8);
      check("lock_tick", {31'd0, tick[0]}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         restart(vecs[i].div);
         count_level(1'b1, h);
         check("vec_high", h, vecs[i].exp_high);
         count_level(1'b0, l);
         check("vec_low", l, vecs[i].exp_low);
         check("vec_tick", {31'd0, tick[0]}, 32'd1);
      end
      // divide change mid-high only affects later periods
      restart(8'd7);
      step();
      step();
      div_val[7:0] = 8'd3;
      count_level(1'b1, h);
      check("chg_high", h + 2, 8);
      count_level(1'b0, l);
      check("chg_low", l, 8);
      check("chg_tick", {31'd0, tick[0]}, 32'd1);
      count_level(1'b1, h);
      check("new_high", h, 4);
      count_level(1'b0, l);
      check("new_low", l, 4);
      check("new_tick", {31'd0, tick[0]}, 32'd1);
      // disable three cycles into high phase
      restart(8'd7);
      repeat (3) step();
      ch_en[0] = 1'b0;
      count_level(1'b1, h);
      check("dis_high", h, 5);
      count_level(1'b0, l);
      check("dis_held_low", l, 100);
      // lock loss and relock
      ch_en = 4'b0011;
      div_val[7:0] = 8'd7;
      div_val[15:8] = 8'd3;
      step();
      check("two_start", {28'd0, outclk}, 32'd3);
      repeat (3) step();
      pll_locked = 1'b0;
      repeat (4) step();
      check("unlock", {23'd0, locked, outclk, tick}, 32'd0);
      pll_locked = 1'b1;
      found = -1;
      for (int e = 0; e < 30 && found < 0; e++) begin
         step();
         if (tick != 4'b0000) found = e;
      end
      check("relock_edge", found, 19);
      check("relock_tick", {28'd0, tick}, 32'd3);
      check("relock_locked", {31'd0, locked}, 32'd1);
      // phase alignment request with channels out of phase
      repeat (5) step();
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
`ifdef MIC_CLK_GEN_PHASE_ALIGN_EN
      exp_o = 4'b0011;
      exp_t = 4'b0011;
`else
      exp_o = 4'b0001;
      exp_t = 4'b0000;
`endif
      check("sync_edge", {24'd0, outclk, tick}, {24'd0, exp_o, exp_t});
      repeat (16) step();
      check("sync_after", {24'd0, outclk, tick}, {24'd0, exp_o, exp_t});
      check("no_stray_tick", bad_tick, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
